// File: rtl/image_write_pkg.sv
// Shared types and constants for the BMP image write controller.
package image_write_pkg;

    localparam int unsigned PIX_W   = 48;
    localparam int unsigned BYTE_W  = 8;
    localparam int unsigned CKSUM_W = 16;

    // Bit offsets of each byte lane inside a {R0,G0,B0,R1,G1,B1} pair
    localparam int unsigned LANE_R0 = 40;
    localparam int unsigned LANE_G0 = 32;
    localparam int unsigned LANE_B0 = 24;
    localparam int unsigned LANE_R1 = 16;
    localparam int unsigned LANE_G1 = 8;
    localparam int unsigned LANE_B1 = 0;

    localparam int unsigned BMP_BYTES_PER_PAIR = 6;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACTIVE,
        ST_HBLANK,
        ST_DONE
    } state_e;

    // Sum of the six bytes of one pixel pair, modulo 2^16
    function automatic logic [CKSUM_W-1:0] pair_byte_sum(input logic [PIX_W-1:0] p);
        pair_byte_sum = CKSUM_W'(p[LANE_R0 +: BYTE_W]) + CKSUM_W'(p[LANE_G0 +: BYTE_W])
                      + CKSUM_W'(p[LANE_B0 +: BYTE_W]) + CKSUM_W'(p[LANE_R1 +: BYTE_W])
                      + CKSUM_W'(p[LANE_G1 +: BYTE_W]) + CKSUM_W'(p[LANE_B1 +: BYTE_W]);
    endfunction

endpackage

// File: rtl/image_write_ctrl_if.sv
// Pixel-in stream and writer-out beat bundle of the image write controller.
interface image_write_ctrl_if
    import image_write_pkg::*;
#(
    parameter int unsigned ROW_W  = 10,
    parameter int unsigned COL_W  = 9,
    parameter int unsigned ADDR_W = 21
) ();

    logic              in_valid;
    logic              in_ready;
    logic [PIX_W-1:0]  in_pix;
    logic              wr_ready;
    logic              hsync;
    logic [PIX_W-1:0]  wr_pix;
    logic [ROW_W-1:0]  wr_row;
    logic [COL_W-1:0]  wr_col;
    logic [ADDR_W-1:0] wr_addr;

    // Controller side
    modport master (
        input  in_valid, in_pix, wr_ready,
        output in_ready, hsync, wr_pix, wr_row, wr_col, wr_addr
    );

    // Pipeline + writer side
    modport slave (
        output in_valid, in_pix, wr_ready,
        input  in_ready, hsync, wr_pix, wr_row, wr_col, wr_addr
    );

endinterface

// File: rtl/skid_buf2.sv
// Two-entry valid/ready buffer; entry 0 is always the head.
module skid_buf2
    import image_write_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             flush_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [PIX_W-1:0] in_data_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [PIX_W-1:0] out_data_o
);

    logic [1:0]       count_q, count_d;
    logic [PIX_W-1:0] ent0_q, ent0_d;
    logic [PIX_W-1:0] ent1_q, ent1_d;
    logic             push, pop;

    assign in_ready_o  = (count_q != 2'd2);
    assign out_valid_o = (count_q != 2'd0);
    assign out_data_o  = ent0_q;
    assign push        = in_valid_i & in_ready_o;
    assign pop         = out_valid_o & out_ready_i;

    // Occupancy and entry shifting for push/pop/flush
    always_comb begin
        count_d = count_q;
        ent0_d  = ent0_q;
        ent1_d  = ent1_q;
        if (flush_i) begin
            count_d = 2'd0;
            ent0_d  = '0;
            ent1_d  = '0;
        end else begin
            unique case ({push, pop})
                2'b10: begin
                    if (count_q == 2'd0) ent0_d = in_data_i;
                    else                 ent1_d = in_data_i;
                    count_d = count_q + 2'd1;
                end
                2'b01: begin
                    ent0_d  = ent1_q;
                    ent1_d  = '0;
                    count_d = count_q - 2'd1;
                end
                2'b11: begin
                    if (count_q == 2'd1) begin
                        ent0_d = in_data_i;
                    end else begin
                        ent0_d = ent1_q;
                        ent1_d = in_data_i;
                    end
                end
                default: ;
            endcase
        end
    end

    // Buffer state registers
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= 2'd0;
            ent0_q  <= '0;
            ent1_q  <= '0;
        end else begin
            count_q <= count_d;
            ent0_q  <= ent0_d;
            ent1_q  <= ent1_d;
        end
    end

endmodule

// File: rtl/image_write_ctrl.sv
// Frame pacing controller feeding a bottom-up BMP writer.
// Optional checksum output: define IMAGE_WRITE_CTRL_CHECKSUM_EN.
module image_write_ctrl
    import image_write_pkg::*;
#(
    parameter int unsigned WIDTH  = 768,
    parameter int unsigned HEIGHT = 512,
    parameter int unsigned HBLANK = 4,
    parameter int unsigned ADDR_W = 21,
    parameter int unsigned ROW_W  = 10,
    parameter int unsigned COL_W  = 9
) (
    input  logic                HCLK,
    input  logic                HRESET,
    input  logic                start,
    image_write_ctrl_if.master  bus,
    output logic                busy,
    output logic                frame_done
`ifdef IMAGE_WRITE_CTRL_CHECKSUM_EN
    ,
    output logic [CKSUM_W-1:0]  checksum
`endif
);

    localparam int unsigned       BLANK_W    = (HBLANK > 1) ? $clog2(HBLANK) : 1;
    localparam bit                HAS_BLANK  = (HBLANK != 0);
    localparam logic [BLANK_W-1:0] BLANK_LOAD = BLANK_W'((HBLANK > 0) ? HBLANK - 1 : 0);
    localparam logic [COL_W-1:0]  LAST_COL   = COL_W'(WIDTH / 2 - 1);
    localparam logic [ROW_W-1:0]  LAST_ROW   = ROW_W'(HEIGHT - 1);
    localparam logic [ADDR_W-1:0] ROW_BYTES  = ADDR_W'(WIDTH * 3);
    localparam logic [ADDR_W-1:0] LAST_ROW_A = ADDR_W'(HEIGHT - 1);
    localparam logic [ADDR_W-1:0] PAIR_BYTES = ADDR_W'(BMP_BYTES_PER_PAIR);

    state_e             state_q, state_d;
    logic [ROW_W-1:0]   row_q, row_d;
    logic [COL_W-1:0]   col_q, col_d;
    logic [BLANK_W-1:0] blank_q, blank_d;
    logic               hsync_c, flush_c, accept_en_c;
    logic               sb_ready, head_valid;
    logic [PIX_W-1:0]   head_data;
    logic [ADDR_W-1:0]  addr_c;

    assign accept_en_c = (state_q == ST_ACTIVE) || (state_q == ST_HBLANK);

    skid_buf2 u_skid (
        .clk         (HCLK),
        .rst         (HRESET),
        .flush_i     (flush_c),
        .in_valid_i  (bus.in_valid & accept_en_c),
        .in_ready_o  (sb_ready),
        .in_data_i   (bus.in_pix),
        .out_valid_o (head_valid),
        .out_ready_i (hsync_c),
        .out_data_o  (head_data)
    );

    // Next-state, counters and beat strobe
    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        col_d   = col_q;
        blank_d = blank_q;
        hsync_c = 1'b0;
        flush_c = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_ACTIVE;
                    row_d   = '0;
                    col_d   = '0;
                end
            end
            ST_ACTIVE: begin
                hsync_c = head_valid & bus.wr_ready;
                if (hsync_c) begin
                    if (col_q == LAST_COL) begin
                        col_d = '0;
                        if (row_q == LAST_ROW) begin
                            row_d   = '0;
                            state_d = ST_DONE;
                        end else begin
                            row_d = row_q + ROW_W'(1);
                            if (HAS_BLANK) begin
                                state_d = ST_HBLANK;
                                blank_d = BLANK_LOAD;
                            end
                        end
                    end else begin
                        col_d = col_q + COL_W'(1);
                    end
                end
            end
            ST_HBLANK: begin
                if (blank_q == '0) state_d = ST_ACTIVE;
                else               blank_d = blank_q - BLANK_W'(1);
            end
            ST_DONE: begin
                flush_c = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM and counter registers
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state_q <= ST_IDLE;
            row_q   <= '0;
            col_q   <= '0;
            blank_q <= '0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            col_q   <= col_d;
            blank_q <= blank_d;
        end
    end

    // Bottom-up BMP byte address of B0 for the current row/col
    assign addr_c = ROW_BYTES * (LAST_ROW_A - ADDR_W'(row_q)) + PAIR_BYTES * ADDR_W'(col_q);

    // Beat fields are zeroed outside a beat so idle/reset values read as 0
    assign bus.hsync    = hsync_c;
    assign bus.wr_pix   = hsync_c ? head_data : '0;
    assign bus.wr_row   = hsync_c ? row_q     : '0;
    assign bus.wr_col   = hsync_c ? col_q     : '0;
    assign bus.wr_addr  = hsync_c ? addr_c    : '0;
    assign bus.in_ready = accept_en_c & sb_ready;
    assign busy         = (state_q != ST_IDLE);
    assign frame_done   = (state_q == ST_DONE);

`ifdef IMAGE_WRITE_CTRL_CHECKSUM_EN
    logic [CKSUM_W-1:0] cksum_q;

    // Running byte sum of the frame, cleared by an accepted start
    always_ff @(posedge HCLK) begin
        if (HRESET)                            cksum_q <= '0;
        else if (state_q == ST_IDLE && start)  cksum_q <= '0;
        else if (hsync_c)                      cksum_q <= cksum_q + pair_byte_sum(head_data);
    end

    assign checksum = cksum_q;
`endif

endmodule

// File: tb/tb_image_write_ctrl.sv
// Randomized self-checking bench for image_write_ctrl (small 8x4 frame).
module tb_image_write_ctrl;
    import image_write_pkg::*;

    localparam int unsigned W = 8, H = 4, HB = 2;
    localparam int unsigned AW = 21, RW = 10, CW = 9;
    localparam int unsigned PAIRS = W / 2, TOTAL = W * H / 2;

    logic HCLK = 1'b0;
    logic HRESET, start, start_b;
    logic busy_a, done_a, busy_b, done_b;
`ifdef IMAGE_WRITE_CTRL_CHECKSUM_EN
    logic [15:0] cks_a, cks_b;
`endif

    always #5 HCLK = ~HCLK;

    image_write_ctrl_if #(.ROW_W(RW), .COL_W(CW), .ADDR_W(AW)) bus_a ();
    image_write_ctrl_if #(.ROW_W(RW), .COL_W(CW), .ADDR_W(AW)) bus_b ();

    image_write_ctrl #(.WIDTH(W), .HEIGHT(H), .HBLANK(HB), .ADDR_W(AW), .ROW_W(RW), .COL_W(CW)) dut_a (
        .HCLK(HCLK), .HRESET(HRESET), .start(start), .bus(bus_a),
        .busy(busy_a), .frame_done(done_a)
`ifdef IMAGE_WRITE_CTRL_CHECKSUM_EN
        , .checksum(cks_a)
`endif
    );

    image_write_ctrl #(.WIDTH(W), .HEIGHT(H), .HBLANK(0), .ADDR_W(AW), .ROW_W(RW), .COL_W(CW)) dut_b (
        .HCLK(HCLK), .HRESET(HRESET), .start(start_b), .bus(bus_b),
        .busy(busy_b), .frame_done(done_b)
`ifdef IMAGE_WRITE_CTRL_CHECKSUM_EN
        , .checksum(cks_b)
`endif
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model state
    logic [47:0] q[$];
    bit          mon_en = 1'b0;
    bit          m_run  = 1'b0;
    int          beat   = 0;
    int          frames = 0;
    int          cyc    = 0;
    int          last_beat_cyc = 0;
    logic [15:0] m_cks  = 16'd0;
    int          mode   = 0;
    bit          tgl    = 1'b0;

    int b_cnt = 0, b_first = 0, b_last = 0, b_done = 0;

    // Model of DUT A: expected beats derived from frame geometry and accepted pairs
    always @(negedge HCLK) begin
        logic [47:0] exp_pix;
        int unsigned exp_row, exp_col, exp_addr;
        bit nostall;
        cyc++;
        nostall = (mode == 0) || (mode == 3);
        if (HRESET) begin
            m_run = 1'b0;
            beat  = 0;
            q.delete();
        end else if (mon_en) begin
            check("busy", 64'(busy_a), 64'(m_run));
            check("in_ready", 64'(bus_a.in_ready), 64'(m_run && beat < TOTAL && q.size() < 2));
            check("frame_done", 64'(done_a), 64'(m_run && beat == TOTAL));
            if (bus_a.hsync) begin
                check("beat_in_frame", 64'(m_run && beat < TOTAL), 64'd1);
                exp_row  = beat / PAIRS;
                exp_col  = beat % PAIRS;
                exp_addr = W * 3 * (H - 1 - exp_row) + 6 * exp_col;
                check("wr_row", 64'(bus_a.wr_row), 64'(exp_row));
                check("wr_col", 64'(bus_a.wr_col), 64'(exp_col));
                check("wr_addr", 64'(bus_a.wr_addr), 64'(exp_addr));
                if (q.size() == 0) begin
                    check("pop_empty", 64'd1, 64'd0);
                end else begin
                    exp_pix = q.pop_front();
                    check("wr_pix", 64'(bus_a.wr_pix), 64'(exp_pix));
                    for (int i = 0; i < 6; i++) m_cks += 16'(exp_pix[i*8 +: 8]);
                end
                if (nostall && beat > 0)
                    check("gap", 64'(cyc - last_beat_cyc - 1), 64'((exp_col == 0) ? HB : 0));
                last_beat_cyc = cyc;
                beat++;
            end
            if (bus_a.in_valid && bus_a.in_ready) q.push_back(bus_a.in_pix);
            if (done_a) begin
                frames++;
                check("done_after_last", 64'(cyc - last_beat_cyc), 64'd1);
                check("beat_count", 64'(beat), 64'(TOTAL));
`ifdef IMAGE_WRITE_CTRL_CHECKSUM_EN
                check("checksum", 64'(cks_a), 64'(m_cks));
`endif
                m_run = 1'b0;
                q.delete();
            end else if (start && !m_run) begin
                m_run = 1'b1;
                beat  = 0;
                m_cks = 16'd0;
            end
        end
    end

    // DUT B (no blanking): beats counted and positions checked
    always @(negedge HCLK) begin
        if (!HRESET && bus_b.hsync) begin
            if (b_cnt == 0) b_first = cyc;
            check("b_row", 64'(bus_b.wr_row), 64'(b_cnt / PAIRS));
            check("b_col", 64'(bus_b.wr_col), 64'(b_cnt % PAIRS));
            b_cnt++;
            b_last = cyc;
        end
        if (!HRESET && done_b) b_done++;
    end

    task automatic apply_stim();
        case (mode)
            0: begin bus_a.in_valid = 1'b1; bus_a.wr_ready = 1'b1; bus_a.in_pix = 48'({$urandom, $urandom}); end
            1: begin bus_a.in_valid = 1'b1; bus_a.wr_ready = tgl; tgl = ~tgl; bus_a.in_pix = 48'({$urandom, $urandom}); end
            2: begin
                bus_a.in_valid = ($urandom_range(0, 3) != 0);
                bus_a.wr_ready = ($urandom_range(0, 2) != 0);
                bus_a.in_pix   = 48'({$urandom, $urandom});
            end
            default: begin bus_a.in_valid = 1'b1; bus_a.wr_ready = 1'b1; bus_a.in_pix = 48'h010101010101; end
        endcase
        bus_b.in_pix = 48'({$urandom, $urandom});
    endtask

    task automatic step();
        @(posedge HCLK);
        #1;
        apply_stim();
    endtask

    task automatic do_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic wait_beats(input int n);
        int budget = 500;
        while (beat < n && budget > 0) begin step(); budget--; end
        if (budget == 0) check("timeout_beats", 64'd0, 64'd1);
    endtask

    task automatic wait_done();
        int f0 = frames;
        int budget = 600;
        while (frames == f0 && budget > 0) begin step(); budget--; end
        if (budget == 0) check("timeout_done", 64'd0, 64'd1);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_hsync"},    64'(bus_a.hsync), 64'd0);
        check({tag, "_in_ready"}, 64'(bus_a.in_ready), 64'd0);
        check({tag, "_wr_pix"},   64'(bus_a.wr_pix), 64'd0);
        check({tag, "_wr_row"},   64'(bus_a.wr_row), 64'd0);
        check({tag, "_wr_col"},   64'(bus_a.wr_col), 64'd0);
        check({tag, "_wr_addr"},  64'(bus_a.wr_addr), 64'd0);
        check({tag, "_busy"},     64'(busy_a), 64'd0);
        check({tag, "_done"},     64'(done_a), 64'd0);
`ifdef IMAGE_WRITE_CTRL_CHECKSUM_EN
        check({tag, "_checksum"}, 64'(cks_a), 64'd0);
`endif
    endtask

    initial begin
        int f0, budget;
        HRESET = 1'b1; start = 1'b0; start_b = 1'b0;
        bus_a.in_valid = 1'b0; bus_a.wr_ready = 1'b0; bus_a.in_pix = '0;
        bus_b.in_valid = 1'b1; bus_b.wr_ready = 1'b1; bus_b.in_pix = '0;
        repeat (3) step();
        HRESET = 1'b0;
        step();
        @(negedge HCLK);
        check_reset_values("por");
        mon_en = 1'b1;

        // Free-running frame, wr_ready toggling, fully random handshakes
        for (int m = 0; m < 3; m++) begin
            mode = m;
            step();
            do_start();
            wait_done();
            repeat (3) step();
        end

        // Second start during row 1 must be ignored
        mode = 0;
        f0 = frames;
        do_start();
        wait_beats(PAIRS + 1);
        do_start();
        wait_done();
        repeat (8) step();
        check("single_done", 64'(frames - f0), 64'd1);

        // Reset in the middle of a frame, then a clean frame
        f0 = frames;
        do_start();
        wait_beats(5);
        HRESET = 1'b1;
        step();
        HRESET = 1'b0;
        @(negedge HCLK);
        check_reset_values("mid_rst");
        check("no_done_on_reset", 64'(frames - f0), 64'd0);
        step();
        do_start();
        wait_done();
        check("frame_after_reset", 64'(frames - f0), 64'd1);

`ifdef IMAGE_WRITE_CTRL_CHECKSUM_EN
        // All bytes 0x01: 16 beats * 6 bytes
        mode = 3;
        step();
        do_start();
        wait_done();
        step();
        check("checksum_ones", 64'(cks_a), 64'd96);
        mode = 0;
`endif

        // No-blanking instance: 16 back-to-back beats
        start_b = 1'b1;
        step();
        start_b = 1'b0;
        budget = 200;
        while (b_done == 0 && budget > 0) begin step(); budget--; end
        if (budget == 0) check("timeout_b", 64'd0, 64'd1);
        step();
        check("b_beats", 64'(b_cnt), 64'(TOTAL));
        check("b_span", 64'(b_last - b_first), 64'(TOTAL - 1));
        check("b_done", 64'(b_done), 64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/image_write_ctrl.md
Name: image_write_ctrl

Overview:
- Frame-level controller that sits between the pixel-processing pipeline and the .bmp image writer.
- Accepts a valid/ready stream of pixel pairs, buffers it in a 2-entry skid buffer, and paces it row by row with programmable horizontal blanking.
- Drives the writer's hsync strobe with row/col indices and a bottom-up BMP byte address.
- Emits a frame_done pulse after the final pair of the frame.

Parameters:
- WIDTH, 768, image width in pixels; must be even.
- HEIGHT, 512, image height in rows.
- HBLANK, 4, idle cycles inserted after each row except the last; 0 means no gap.
- ADDR_W, 21, width of the byte address; must satisfy 2^ADDR_W >= WIDTH*HEIGHT*3.
- ROW_W, 10, row counter width.
- COL_W, 9, pair-column counter width; counts 0..WIDTH/2-1.

Ports:
- HCLK  in  1  clock; all logic on the rising edge.
- HRESET  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse that begins a frame.
- in_valid  in  1  upstream pair valid.
- in_ready  out  1  controller can accept a pair.
- in_pix  in  48  {R0,G0,B0,R1,G1,B1}, 8 bits each; pixel 0 is the left pixel of the pair.
- wr_ready  in  1  writer can accept a beat this cycle.
- hsync  out  1  beat strobe to the writer; wr_* outputs are valid when hsync=1.
- wr_pix  out  48  pair being written, same packing as in_pix.
- wr_row  out  ROW_W  image row of the beat; 0 = top.
- wr_col  out  COL_W  pair column of the beat.
- wr_addr  out  ADDR_W  byte address of B0: WIDTH*3*(HEIGHT-1-wr_row) + 6*wr_col.
- busy  out  1  high in every state except IDLE.
- frame_done  out  1  one-cycle pulse at the end of the frame.

Behaviour:
- Reset values: in_ready=0, hsync=0, wr_pix=0, wr_row=0, wr_col=0, wr_addr=0, busy=0, frame_done=0. Reset also clears the skid buffer, both counters and the FSM. Reset mid-frame discards all buffered pairs; no frame_done is issued.
- FSM states: IDLE, ACTIVE, HBLANK, DONE.
  - IDLE: in_ready=0. On start, move to ACTIVE and clear row/col to 0.
  - ACTIVE: hsync = buf_nonempty & wr_ready (combinational from registered buffer state). On each hsync, the head entry is popped and col increments.
  - ACTIVE, on hsync with col==WIDTH/2-1: col->0 and row increments. If row==HEIGHT-1, go to DONE. Else go to HBLANK if HBLANK>0, or stay in ACTIVE if HBLANK==0.
  - HBLANK: hsync=0. A down-counter loads HBLANK-1 on entry and returns to ACTIVE when it reaches 0, so exactly HBLANK cycles without hsync occur.
  - DONE: frame_done=1 for exactly one cycle, then IDLE. Any pairs still in the buffer are flushed.
- start is ignored when not in IDLE.
- in_ready = (state != IDLE) & (state != DONE) & buffer not full. The buffer fills during HBLANK.
- Pop and push in the same cycle are allowed; occupancy is unchanged.
- Latency: a pair accepted at cycle N can appear on hsync at N+1 at the earliest.
- Throughput: 1 beat per cycle with wr_ready held high.
- wr_row, wr_col, wr_pix and wr_addr are combinational from the head entry and the counters; they must be stable whenever hsync=1.
- wr_addr arithmetic is done at ADDR_W width with no truncation for the default parameters.
- Frame length is WIDTH*HEIGHT/2 beats; 196608 beats at default parameters.

Optional Feature:
- Macro: IMAGE_WRITE_CTRL_CHECKSUM_EN.
- Defined: adds output port checksum [15:0]. It holds the mod-2^16 sum of all six bytes of every hsync beat in the frame. It clears on start, is valid while frame_done=1, and holds its value until the next start. Reset value is 0.
- Undefined: the port and its logic are absent.

Decomposition:
- Package image_write_pkg holds:
  - FSM state enum;
  - byte-lane index constants R0..B1 (bit offsets 40, 32, 24, 16, 8, 0);
  - BMP_BYTES_PER_PAIR = 6.
- Sub-module skid_buf2: 2-entry valid/ready buffer, 48 bits wide, synchronous active-high reset.

Test Plan:
- WIDTH=8, HEIGHT=4, HBLANK=2, in_valid and wr_ready held high, start pulse:
  - 16 hsync beats occur, with exactly 2 idle cycles after each of rows 0-2;
  - the first beat has wr_addr=72 and the last has wr_addr=18;
  - frame_done pulses once, one cycle after the final beat.
- Same configuration, wr_ready toggling 1/0 every cycle:
  - in_ready deasserts once 2 pairs are buffered;
  - the beat sequence and data match the no-stall run;
  - no pair is lost or duplicated.
- start pulsed again mid-frame at row 1 -> ignored; counters continue and a single frame_done is issued.
- HRESET asserted for 1 cycle at beat 5:
  - all outputs return to reset values and busy=0;
  - a subsequent start produces a complete 16-beat frame starting at row 0, col 0.
- HBLANK=0 -> 16 consecutive hsync cycles with no gaps between rows.
- IMAGE_WRITE_CTRL_CHECKSUM_EN defined, every byte of every pair = 8'h01 -> checksum = 16'd96 at frame_done.
